// File: rtl/shiftq_ctrl.sv
// Sequencing controller for a DEPTH-stage shift-register queue: per-stage enable/select,
// occupancy tracking, push/pop handshakes, flush and high-watermark.

module shiftq_stage #(
  parameter int DEPTH = 8,
  parameter int CW    = 4,
  parameter int IDX   = 0
) (
  input  logic [CW-1:0] count,
  input  logic          push_fire,
  input  logic          pop_fire,
  output logic          enb,
  output logic          sel
);
  localparam logic [CW-1:0] POS  = CW'(IDX);
  localparam logic [CW-1:0] POS1 = CW'(IDX + 1);

  logic shift, load;

  // On a simultaneous push/pop the new word lands one slot lower, behind the shifted tail.
  always_comb begin
    shift = pop_fire && (POS1 < count);
    load  = push_fire && (pop_fire ? (POS1 == count) : (POS == count));
    enb   = shift | load;
    sel   = load;
  end
endmodule

module shiftq_ctrl #(
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic             pop_req,
  output logic             pop_valid,
  input  logic             flush,
  output logic [DEPTH-1:0] enb,
  output logic [DEPTH-1:0] sel,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    hwm
);
  logic          pop_fire, push_fire;
  logic [CW-1:0] cnt_nxt;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign pop_valid  = !empty && !flush && !rst;
  assign pop_fire   = pop_req && pop_valid;
  assign push_ready = (!full || pop_fire) && !flush && !rst;
  assign push_fire  = push_valid && push_ready;

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_stage
      shiftq_stage #(.DEPTH(DEPTH), .CW(CW), .IDX(i)) u_stage (
        .count     (count),
        .push_fire (push_fire),
        .pop_fire  (pop_fire),
        .enb       (enb[i]),
        .sel       (sel[i])
      );
    end
  endgenerate

  always_comb begin
    cnt_nxt = count;
    case ({push_fire, pop_fire})
      2'b10:   cnt_nxt = count + 1'b1;
      2'b01:   cnt_nxt = count - 1'b1;
      default: cnt_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
      hwm   <= '0;
    end else begin
      count <= cnt_nxt;
      hwm   <= (cnt_nxt > hwm) ? cnt_nxt : hwm;
    end
  end
endmodule

// File: tb/tb_shiftq_ctrl.sv
// Bench: shiftq_ctrl driving a 4-stage register chain, checked against a queue model
// every cycle plus hand-computed literal expectations.

module tb_shiftq_ctrl;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic             clk = 0;
  logic             rst = 0;
  logic             push_valid = 0, pop_req = 0, flush = 0;
  logic [31:0]      din = 0;
  logic             push_ready, pop_valid, full, empty;
  logic [DEPTH-1:0] enb, sel;
  logic [CW-1:0]    count, hwm;

  logic [31:0] chain [DEPTH];
  logic [31:0] q [$];
  int          mhwm = 0;
  int          errors = 0, checks = 0;
  bit          chk_en = 0;

  shiftq_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push_valid(push_valid), .push_ready(push_ready),
    .pop_req(pop_req), .pop_valid(pop_valid), .flush(flush), .enb(enb), .sel(sel),
    .count(count), .full(full), .empty(empty), .hwm(hwm)
  );

  always #5 clk = ~clk;

  // register chain as the wrapper would build it
  always @(posedge clk)
    for (int k = 0; k < DEPTH; k++)
      if (enb[k]) chain[k] <= sel[k] ? din : ((k < DEPTH - 1) ? chain[(k + 1) % DEPTH] : 32'h0);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // queue model: checks on the falling edge, then advances to the post-edge state
  always @(negedge clk) begin
    bit e_pv, e_pr, pf, psh;
    e_pv = (q.size() != 0) && !flush && !rst;
    pf   = pop_req && e_pv;
    e_pr = ((q.size() < DEPTH) || pf) && !flush && !rst;
    psh  = push_valid && e_pr;
    if (chk_en) begin
      chk("pop_valid", pop_valid, e_pv);
      chk("push_ready", push_ready, e_pr);
      chk("count", count, q.size());
      chk("full", full, q.size() == DEPTH);
      chk("empty", empty, q.size() == 0);
      chk("hwm", hwm, mhwm);
      chk("sel_without_enb", sel & ~enb, 0);
      if (!pf && !psh) chk("enb_idle", enb, 0);
      for (int k = 0; k < q.size(); k++) chk($sformatf("chain%0d", k), chain[k], q[k]);
    end
    if (rst || flush) begin
      q.delete();
      mhwm = 0;
    end else begin
      if (pf) void'(q.pop_front());
      if (psh) q.push_back(din);
      if (q.size() > mhwm) mhwm = q.size();
    end
  end

  task automatic drive(input logic pv, input logic pr, input logic fl, input logic r,
                       input logic [31:0] d);
    @(posedge clk);
    #1;
    push_valid = pv; pop_req = pr; flush = fl; rst = r; din = d;
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 1, 0);
    chk("rst_push_ready", push_ready, 0);
    chk("rst_enb", enb, 0);
    drive(1, 0, 0, 0, 32'h11);
    chk_en = 1;
    chk("reset_count", count, 0);
    chk("reset_hwm", hwm, 0);
    chk("push1_enb", enb, 4'b0001);
    chk("push1_sel", sel, 4'b0001);
    drive(1, 0, 0, 0, 32'h22);
    chk("push2_enb", enb, 4'b0010);
    chk("push2_sel", sel, 4'b0010);
    chk("push2_count", count, 1);
    drive(1, 0, 0, 0, 32'h33);
    chk("push3_enb", enb, 4'b0100);
    drive(1, 0, 0, 0, 32'h44);
    chk("push4_enb", enb, 4'b1000);
    chk("push4_sel", sel, 4'b1000);
    drive(1, 0, 0, 0, 32'h55);
    chk("full_push_ready", push_ready, 0);
    chk("full_enb", enb, 0);
    chk("full_count", count, 4);
    chk("full_flag", full, 1);
    chk("full_hwm", hwm, 4);
    drive(0, 1, 0, 0, 0);
    chk("pop_enb", enb, 4'b0111);
    chk("pop_sel", sel, 4'b0000);
    drive(0, 0, 0, 0, 0);
    chk("pop_head", chain[0], 32'h22);
    chk("pop_count", count, 3);
    chk("pop_full", full, 0);
    chk("pop_hwm", hwm, 4);
    drive(1, 1, 1, 0, 32'h66);
    chk("flush_push_ready", push_ready, 0);
    chk("flush_enb", enb, 0);
    drive(0, 0, 0, 0, 0);
    chk("flush_count", count, 0);
    chk("flush_hwm", hwm, 0);
    chk("flush_empty", empty, 1);
    drive(1, 0, 0, 0, 32'hA);
    drive(1, 0, 0, 0, 32'hB);
    drive(1, 1, 0, 0, 32'hC);
    chk("pp2_enb", enb, 4'b0011);
    chk("pp2_sel", sel, 4'b0010);
    drive(0, 0, 0, 0, 0);
    chk("pp2_head", chain[0], 32'hB);
    chk("pp2_stage1", chain[1], 32'hC);
    chk("pp2_count", count, 2);
    drive(1, 0, 0, 0, 32'hD);
    drive(1, 0, 0, 0, 32'hE);
    drive(1, 1, 0, 0, 32'hF);
    chk("ppfull_push_ready", push_ready, 1);
    chk("ppfull_enb", enb, 4'b1111);
    chk("ppfull_sel", sel, 4'b1000);
    drive(0, 0, 0, 0, 0);
    chk("ppfull_count", count, 4);
    chk("ppfull_head", chain[0], 32'hC);
    chk("ppfull_tail", chain[3], 32'hF);
    drive(0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 0, 0);
      chk("empty_pop_valid", pop_valid, 0);
      chk("empty_enb", enb, 0);
      chk("empty_count", count, 0);
    end
    drive(1, 0, 0, 0, 32'h77);
    drive(1, 1, 0, 0, 32'h88);
    chk("pp1_enb", enb, 4'b0001);
    chk("pp1_sel", sel, 4'b0001);
    drive(0, 0, 0, 0, 0);
    chk("pp1_head", chain[0], 32'h88);
    chk("pp1_count", count, 1);
    drive(1, 0, 0, 0, 32'h99);
    drive(1, 0, 0, 0, 32'hAA);
    drive(1, 0, 0, 1, 32'hBB);
    chk("rstmid_enb", enb, 0);
    chk("rstmid_push_ready", push_ready, 0);
    drive(0, 0, 0, 0, 0);
    chk("rstmid_count", count, 0);
    chk("rstmid_hwm", hwm, 0);
    for (int k = 0; k < 80; k++)
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 15) == 0, 0, $urandom);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/shiftq_ctrl.md
Name: shiftq_ctrl

Overview:
- Sequencing controller for a shift-register queue built from a chain of DEPTH 32-bit enabled register stages (d/q/enb).
- Stage 0 is the queue head; its q output is the pop data.
- The block generates a per-stage enable and a per-stage input-select, tracks occupancy, and provides the push/pop handshakes, flush and a high-watermark status.
- It contains no data storage itself. A top-level wrapper instantiates it with the register chain and a 2:1 mux in front of each stage's d input.

Parameters:
- DEPTH, 8, number of register stages in the chain; legal range 2..64.
- CW, $clog2(DEPTH+1), width of the occupancy counters (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- push_valid  input  1  the producer presents a word on the shared datapath input.
- push_ready  output  1  the controller accepts the word this cycle.
- pop_req  input  1  the consumer takes the head word (stage 0 q) this cycle.
- pop_valid  output  1  stage 0 holds a valid word.
- flush  input  1  empties the queue in one cycle.
- enb  output  DEPTH  per-stage register enable; enb[i] drives stage i.
- sel  output  DEPTH  per-stage d mux select: 1 = the datapath input word, 0 = stage i+1 q (shift toward the head).
- count  output  CW  number of valid words held.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- hwm  output  CW  maximum count reached since the last reset or flush.

Behaviour:
- Reset: synchronous, active-high. On the clock edge with rst=1, count and hwm go to 0.
  - While rst=1, the outputs push_ready, pop_valid, enb and sel are forced to 0.
  - Reset mid-operation discards all words; no enable pulses are issued in that cycle.
- Fire terms (combinational):
  - pop_valid = !empty && !flush && !rst.
  - pop_fire = pop_req && pop_valid.
  - push_ready = (!full || pop_fire) && !flush && !rst. A push is accepted when full only if a pop fires in the same cycle.
  - push_fire = push_valid && push_ready.
- enb/sel generation (combinational, same cycle as the fire terms; the register chain captures on that clock edge, so latency is 0 cycles):
  - Neither fire: enb = 0.
  - Pop only: enb[i] = 1 and sel[i] = 0 for all i < count-1. Stage count-1 is left unchanged; it is stale and not valid.
  - Push only: enb[count] = 1 and sel[count] = 1.
  - Push and pop together: enb[i] = 1, sel[i] = 0 for i < count-1, and enb[count-1] = 1, sel[count-1] = 1.
    - With count = 1, this reduces to enb[0] = 1, sel[0] = 1.
  - Every bit of sel whose stage is not enabled is 0.
  - sel[DEPTH-1] = 0 never coincides with enb[DEPTH-1] = 1.
- Counter updates (registered):
  - Push only: count increments by 1.
  - Pop only: count decrements by 1.
  - Both, or neither: count is unchanged.
  - Flush: count <= 0 and hwm <= 0. Flush has priority over push and pop; both fires are suppressed, enb = 0 and push_ready = 0.
  - hwm <= max(hwm, next count) every cycle, unless reset or flush applies.
- Boundary conditions:
  - count never exceeds DEPTH and never underflows.
  - pop_req while empty is ignored: no enable pulses, count unchanged.
  - push_valid while full without a pop keeps push_ready = 0; the producer must hold its word.
- full, empty and count are decoded from the count register, so they reflect state after the last edge.
- No combinational path from push_valid to push_ready or to pop_valid.
  - pop_req to push_ready is combinational; this path is intended.

Test Plan:
- DEPTH=4, reset, then push 0x11,0x22,0x33,0x44 on consecutive cycles -> enb = 0001,0010,0100,1000 with matching sel; count 1..4; full=1; hwm=4; a fifth push_valid sees push_ready=0.
- From full [0x11,0x22,0x33,0x44], pop once -> enb=0111, sel=0000; head becomes 0x22; count=3; full=0; hwm stays 4.
- count=2 [0xA,0xB], pop_req and push_valid of 0xC together -> enb=0011, sel=0010; next head 0xB, stage1 0xC; count stays 2.
- Full queue, pop_req and push_valid together -> push_ready=1, enb=1111, sel=1000; count stays 4.
- Empty queue, pop_req=1 for 3 cycles -> pop_valid=0, enb=0, count=0.
- count=3, flush=1 with push_valid=1 and pop_req=1 -> push_ready=0, enb=0; next cycle count=0, hwm=0, empty=1.
- Assert rst with count=3 while a push is pending -> enb=0, push_ready=0; next cycle count=0 and hwm=0.
